// File: rtl/fd_opamp_pkg.sv
// Shared types and helpers for the fully differential opamp trim controller.
package fd_opamp_pkg;

  // Width of a channel index; covers up to four opamp channels.
  localparam int CH_IDX_W = 2;

  // Width of the settle counter; covers SETTLE_CYC up to 255.
  localparam int CNT_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SETTLE,
    S_DECIDE,
    S_STORE
  } state_t;

  // Midscale code for a trim DAC of the given width (MSB set, rest clear).
  function automatic logic [7:0] trim_mid(input int unsigned width);
    return 8'(1 << (width - 1));
  endfunction

endpackage

// File: rtl/fd_opamp_sar_core.sv
// One successive-approximation conversion: working code, bit index and
// settle counter, stepped by the controller's SETUP/SETTLE/DECIDE states.
module fd_opamp_sar_core
  import fd_opamp_pkg::*;
#(
  parameter int TRIM_W     = 6,
  parameter int SETTLE_CYC = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  state_t            state,
  input  logic              init,
  input  logic              cmp_in,
  output logic [TRIM_W-1:0] code,
  output logic              settle_done,
  output logic              code_valid
);

  localparam int IDX_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] cnt;

  // Trial-bit sequencing: set the bit, wait for settling, keep or drop it.
  always_ff @(posedge clk) begin
    // NOTE: registers are updated with <= so every flop samples pre-edge values.
    if (!rst_n) begin
      code <= '0;
      idx  <= '0;
      cnt  <= '0;
    end else if (init) begin
      code <= '0;
      idx  <= IDX_W'(TRIM_W - 1);
      cnt  <= '0;
    end else begin
      case (state)
        S_SETUP: begin
          code[idx] <= 1'b1;
          cnt       <= '0;
        end
        S_SETTLE: cnt <= cnt + 1'b1;
        S_DECIDE: begin
          // Comparator high means the trial overshoots the offset.
          if (cmp_in) code[idx] <= 1'b0;
          if (idx != '0) idx <= idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Conversion progress flags consumed by the controller's next-state logic.
  always_comb begin
    settle_done = (state == S_SETTLE) && (cnt == CNT_W'(SETTLE_CYC - 1));
    code_valid  = (state == S_DECIDE) && (idx == '0);
  end

endmodule

// File: rtl/fd_opamp_trim_ctrl.sv
// Offset-trim controller: per-channel trim register bank, channel sequencing
// and IDLE/STORE control around a shared SAR conversion core.
module fd_opamp_trim_ctrl
  import fd_opamp_pkg::*;
#(
  parameter int TRIM_W     = 6,
  parameter int N_CH       = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     start,
  input  logic                     cal_all,
  input  logic [1:0]               ch_sel,
  input  logic                     cmp_in,
  output logic [N_CH*TRIM_W-1:0]   trim_out,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam logic [TRIM_W-1:0] MID = TRIM_W'(trim_mid(TRIM_W));

  state_t              state, state_nxt;
  logic [CH_IDX_W-1:0] ch_q;
  logic                all_q;
  logic [TRIM_W-1:0]   trim_q [N_CH];
  logic [TRIM_W-1:0]   code;
  logic                settle_done, code_valid;
  logic                in_range, start_ok, more_ch;
  logic                init, store_we, done_set, err_set;

  fd_opamp_sar_core #(
    .TRIM_W     (TRIM_W),
    .SETTLE_CYC (SETTLE_CYC)
  ) u_core (
    .clk         (clk),
    .rst_n       (rst_n),
    .state       (state),
    .init        (init),
    .cmp_in      (cmp_in),
    .code        (code),
    .settle_done (settle_done),
    .code_valid  (code_valid)
  );

  // Request qualification and whether a cal_all run has channels left.
  always_comb begin
    in_range = ({1'b0, ch_sel} < (CH_IDX_W + 1)'(N_CH));
    start_ok = start && ena && (cal_all || in_range);
    more_ch  = all_q && (ch_q != CH_IDX_W'(N_CH - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      S_IDLE:   if (start_ok) state_nxt = S_SETUP;
      S_SETUP:  state_nxt = S_SETTLE;
      S_SETTLE: if (settle_done) state_nxt = S_DECIDE;
      S_DECIDE: state_nxt = code_valid ? S_STORE : S_SETUP;
      S_STORE:  state_nxt = more_ch ? S_SETUP : S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Output/control decode of the current state.
  always_comb begin
    busy     = (state != S_IDLE);
    init     = ((state == S_IDLE) && start_ok) || ((state == S_STORE) && more_ch);
    store_we = (state == S_STORE);
    done_set = (state == S_STORE) && !more_ch;
    err_set  = (state == S_IDLE) && start && ena && !cal_all && !in_range;
  end

  // Channel sequencing and the registered done/err pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ch_q  <= '0;
      all_q <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      done <= done_set;
      err  <= err_set;
      if ((state == S_IDLE) && start_ok) begin
        ch_q  <= cal_all ? '0 : ch_sel;
        all_q <= cal_all;
      end else if ((state == S_STORE) && more_ch) begin
        ch_q <= ch_q + 1'b1;
      end
    end
  end

  // Trim register bank: a channel is only overwritten when it reaches STORE.
  always_ff @(posedge clk) begin
    // NOTE: the bank is reset explicitly because the DAC must see midscale out of reset.
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) trim_q[c] <= MID;
    end else begin
      for (int c = 0; c < N_CH; c++)
        if (store_we && (ch_q == CH_IDX_W'(c))) trim_q[c] <= code;
    end
  end

  // Trim bus: the active channel shows each trial while busy.
  always_comb begin
    trim_out = '0;
    for (int c = 0; c < N_CH; c++)
      trim_out[c*TRIM_W +: TRIM_W] = (busy && (ch_q == CH_IDX_W'(c))) ? code : trim_q[c];
  end

endmodule
